// File: rtl/fc_accumulator.sv
// Sequential accumulation stage for one fully-connected neuron: bias plus NUM_INPUTS signed
// terms, either modulo-wrapped or clamped per add, presented on a valid/ready output.
module fc_accumulator #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_INPUTS = 4,
  parameter bit          SATURATE   = 1'b0,
  localparam int unsigned CntW      = $clog2(NUM_INPUTS + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [DATA_WIDTH-1:0] bias,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CntW-1:0]       term_cnt
);

  typedef enum logic {StAccum, StOut} state_e;

  state_e                state_q;
  logic [DATA_WIDTH-1:0] acc_q;
  logic [CntW-1:0]       cnt_q;
  logic                  in_ready_q;
  logic                  out_valid_q;

  logic [DATA_WIDTH-1:0] lhs;
  logic [DATA_WIDTH:0]   sum_wide;
  logic [DATA_WIDTH-1:0] sum_d;
  logic                  accept;

  assign accept = in_valid && in_ready_q;

  // The first term of a neuron adds to the bias; acc_q is stale until then.
  always_comb begin
    lhs      = (cnt_q == '0) ? bias : acc_q;
    sum_wide = {lhs[DATA_WIDTH-1], lhs} + {in_data[DATA_WIDTH-1], in_data};
    sum_d    = sum_wide[DATA_WIDTH-1:0];
    if (SATURATE && (sum_wide[DATA_WIDTH] != sum_wide[DATA_WIDTH-1])) begin
      sum_d = sum_wide[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                   : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StAccum;
      acc_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        StAccum: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            acc_q <= sum_d;
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CntW'(NUM_INPUTS - 1)) begin
              state_q     <= StOut;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end
        StOut: begin
          if (out_ready) begin
            state_q     <= StAccum;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: state_q <= StAccum;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = acc_q;
  assign term_cnt  = cnt_q;

endmodule
